// File: rtl/atm_pkg.sv
// Purpose: shared types and constants for the PIN entry front end of the password checker.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package atm_pkg;

    // Controller states, in the order a normal session walks through them.
    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        GRANTED,
        LOCKED
    } state_t;

    // Keypad codes above the decimal digits. Codes 0xD-0xF have no function.
    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_ENTER  = 4'hB;
    localparam logic [3:0] KEY_LOGOUT = 4'hC;

    // True for a decimal digit key (0-9).
    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Purpose: loadable down-counter; done flags that the count has reached zero.
// Latency: load/decrement take effect on the next rising edge; done is decoded from the count.
// Backpressure: none; the count holds at zero instead of wrapping.
//
// Ports:
//   Clock, Reset   - sole clock, synchronous active-high reset (count -> 0)
//   load, load_val - reload the count; load wins over en
//   en             - decrement by one while the count is non-zero
//   done           - count is zero
module cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/pin_entry_controller.sv
// Purpose: collects keypad digits into a PIN, submits it to the checker, tracks failures and lockout.
// Latency: every output is registered; Submit rises the cycle after ENTER and lasts CHECK_WAIT cycles.
// Backpressure: none; keys that are not meaningful in the current state are dropped.
//
// Ports:
//   Clock, Reset      - sole clock, synchronous active-high reset with priority over everything
//   KeyValid, KeyCode - one-cycle keypad strobe and its code (digits, CLEAR, ENTER, LOGOUT)
//   PassAuthorized    - checker verdict, combinational from Password/Submit
//   Password, Submit  - assembled PIN (first digit in the top nibble) and the check request
//   DigitCount        - digits entered so far
//   SessionOpen       - access granted, session active
//   Reject            - one-cycle pulse for a failed check
//   LockedOut         - too many consecutive failures, keypad disabled
//   FailCount         - consecutive failed checks, saturating at MAX_TRIES
module pin_entry_controller
    import atm_pkg::*;
#(
    parameter int PIN_DIGITS    = 1,
    parameter int MAX_TRIES     = 3,
    parameter int LOCK_CYCLES   = 1000,
    parameter int ENTRY_TIMEOUT = 500,
    parameter int CHECK_WAIT    = 1,
    localparam int PW_W = 4 * PIN_DIGITS,
    localparam int DC_W = $clog2(PIN_DIGITS + 1),
    localparam int FC_W = $clog2(MAX_TRIES + 1)
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            KeyValid,
    input  logic [3:0]      KeyCode,
    input  logic            PassAuthorized,
    output logic [PW_W-1:0] Password,
    output logic            Submit,
    output logic [DC_W-1:0] DigitCount,
    output logic            SessionOpen,
    output logic            Reject,
    output logic            LockedOut,
    output logic [FC_W-1:0] FailCount
);

    // Timers are loaded with (duration - 1) and expire on the edge where they
    // read zero, so the expiring edge is exactly `duration` edges after loading.
    localparam int ET_W = (ENTRY_TIMEOUT > 1) ? $clog2(ENTRY_TIMEOUT) : 1;
    localparam int LT_W = (LOCK_CYCLES   > 1) ? $clog2(LOCK_CYCLES)   : 1;
    localparam int CW_W = (CHECK_WAIT    > 1) ? $clog2(CHECK_WAIT)    : 1;

    localparam logic [ET_W-1:0] ENTRY_RELOAD = ET_W'(ENTRY_TIMEOUT - 1);
    localparam logic [LT_W-1:0] LOCK_RELOAD  = LT_W'(LOCK_CYCLES - 1);
    localparam logic [CW_W-1:0] CHECK_RELOAD = CW_W'(CHECK_WAIT - 1);
    localparam logic [DC_W-1:0] DIGITS_FULL  = DC_W'(PIN_DIGITS);
    localparam logic [FC_W-1:0] TRIES_LIMIT  = FC_W'(MAX_TRIES);

    state_t          state;
    logic [CW_W-1:0] check_cnt;

    logic entry_load;
    logic entry_en;
    logic entry_done;
    logic lock_load;
    logic lock_en;
    logic lock_done;
    logic pin_full;
    logic check_last;
    logic [FC_W-1:0] fail_next;

    assign pin_full   = (DigitCount == DIGITS_FULL);
    assign check_last = (state == CHECK) && (check_cnt == '0);
    assign fail_next  = (FailCount == TRIES_LIMIT) ? FailCount : FailCount + FC_W'(1);

    // Any key while collecting digits restarts the idle window; only key-free
    // cycles in ENTRY count towards the timeout. A key on the expiring edge
    // therefore reloads the timer and is processed normally.
    assign entry_load = KeyValid && ((state == IDLE) || (state == ENTRY));
    assign entry_en   = (state == ENTRY) && !KeyValid;

    // Loaded on every failed sample; it is only observed once in LOCKED.
    assign lock_load = check_last && !PassAuthorized;
    assign lock_en   = (state == LOCKED);

    cycle_timer #(.WIDTH(ET_W)) u_entry_timer (
        .Clock    (Clock),
        .Reset    (Reset),
        .load     (entry_load),
        .load_val (ENTRY_RELOAD),
        .en       (entry_en),
        .done     (entry_done)
    );

    cycle_timer #(.WIDTH(LT_W)) u_lock_timer (
        .Clock    (Clock),
        .Reset    (Reset),
        .load     (lock_load),
        .load_val (LOCK_RELOAD),
        .en       (lock_en),
        .done     (lock_done)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            check_cnt   <= '0;
            Password    <= '0;
            Submit      <= 1'b0;
            DigitCount  <= '0;
            SessionOpen <= 1'b0;
            Reject      <= 1'b0;
            LockedOut   <= 1'b0;
            FailCount   <= '0;
        end else begin
            Reject <= 1'b0;
            case (state)
                IDLE: begin
                    // Password is already zero here, so the digit lands in the LSB nibble.
                    if (KeyValid && is_digit(KeyCode)) begin
                        Password   <= PW_W'(KeyCode);
                        DigitCount <= DC_W'(1);
                        state      <= ENTRY;
                    end
                end

                ENTRY: begin
                    if (KeyValid) begin
                        if (is_digit(KeyCode)) begin
                            if (!pin_full) begin
                                Password   <= (Password << 4) | PW_W'(KeyCode);
                                DigitCount <= DigitCount + DC_W'(1);
                            end
                        end else if (KeyCode == KEY_CLEAR) begin
                            Password   <= '0;
                            DigitCount <= '0;
                            state      <= IDLE;
                        end else if ((KeyCode == KEY_ENTER) && pin_full) begin
                            Submit    <= 1'b1;
                            check_cnt <= CHECK_RELOAD;
                            state     <= CHECK;
                        end
                    end else if (entry_done) begin
                        // Abandoned entry: same effect as CLEAR.
                        Password   <= '0;
                        DigitCount <= '0;
                        state      <= IDLE;
                    end
                end

                CHECK: begin
                    // Password stays put for the whole Submit window; the
                    // verdict is taken on the edge that ends the last cycle.
                    if (check_cnt != '0) begin
                        check_cnt <= check_cnt - CW_W'(1);
                    end else begin
                        Submit <= 1'b0;
                        if (PassAuthorized) begin
                            FailCount   <= '0;
                            SessionOpen <= 1'b1;
                            state       <= GRANTED;
                        end else begin
                            Reject     <= 1'b1;
                            FailCount  <= fail_next;
                            Password   <= '0;
                            DigitCount <= '0;
                            if (fail_next == TRIES_LIMIT) begin
                                LockedOut <= 1'b1;
                                state     <= LOCKED;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end

                GRANTED: begin
                    // Password is kept: downstream identifies the account from it.
                    if (KeyValid && (KeyCode == KEY_LOGOUT)) begin
                        Password    <= '0;
                        DigitCount  <= '0;
                        SessionOpen <= 1'b0;
                        state       <= IDLE;
                    end
                end

                LOCKED: begin
                    if (lock_done) begin
                        LockedOut <= 1'b0;
                        FailCount <= '0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
